// File: rtl/control_fsm.sv
// Multi-cycle RV32I+Zicsr+mret control FSM: decode, memory wait, traps.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetched_instr,
  input  logic        int_req,
  input  logic        mem_ready,
  input  logic [1:0]  mem_addr_lo,
  output logic [1:0]  src_A,
  output logic [2:0]  src_B,
  output logic [4:0]  ALUOp,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic        gpr_we_a,
  output logic        wb_src_sel,
  output logic        illegal_instr,
  output logic        branch,
  output logic        jal,
  output logic [1:0]  jalr,
  output logic [2:0]  CSROp,
  output logic        csr,
  output logic        enpc,
  output logic        INT_RST,
  output logic [31:0] trap_cause
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [31:0] CAUSE_ILL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_LMIS  = 32'h0000_0004;
  localparam logic [31:0] CAUSE_LFLT  = 32'h0000_0005;
  localparam logic [31:0] CAUSE_SMIS  = 32'h0000_0006;
  localparam logic [31:0] CAUSE_SFLT  = 32'h0000_0007;
  localparam logic [31:0] CAUSE_IRQ   = 32'h8000_000B;

  typedef enum logic [1:0] {
    DECODE,
    MEM_WAIT,
    TRAP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             int_pend, pend_nxt;
  logic [31:0]      cause_q, cause_nxt;

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = fetched_instr[6:2];
  assign f3  = fetched_instr[14:12];
  assign f7  = fetched_instr[31:25];

  logic       unused_bits;
  assign unused_bits = ^{fetched_instr[24:15], fetched_instr[11:7]};

  logic [1:0] d_a;
  logic [2:0] d_b;
  logic [4:0] d_alu;
  logic       d_we, d_wb, d_mreq, d_mwe;
  logic [2:0] d_size;
  logic       d_br, d_jal, d_csr, d_mret;
  logic [1:0] d_jalr;
  logic [2:0] d_csrop;
  logic       d_ill, d_ld, d_st;
  logic       misal;

  // Pure instruction decode, shared by DECODE and MEM_WAIT.
  always_comb begin
    d_a     = 2'd0;
    d_b     = 3'd0;
    d_alu   = 5'd0;
    d_we    = 1'b0;
    d_wb    = 1'b0;
    d_mreq  = 1'b0;
    d_mwe   = 1'b0;
    d_size  = 3'd0;
    d_br    = 1'b0;
    d_jal   = 1'b0;
    d_jalr  = 2'b00;
    d_csrop = 3'd0;
    d_csr   = 1'b0;
    d_mret  = 1'b0;
    d_ill   = 1'b0;
    d_ld    = 1'b0;
    d_st    = 1'b0;
    if (fetched_instr[1:0] != 2'b11) begin
      d_ill = 1'b1;
    end else begin
      unique case (opc)
        OPC_OP: begin
          d_we = 1'b1;
          if (f7 == 7'h00)
            d_alu = {2'b00, f3};
          else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
            d_alu = {2'b01, f3};
          else
            d_ill = 1'b1;
        end
        OPC_OP_IMM: begin
          d_b  = 3'd1;
          d_we = 1'b1;
          if (f3 == 3'b001) begin
            d_alu = {2'b00, f3};
            d_ill = (f7 != 7'h00);
          end else if (f3 == 3'b101) begin
            if (f7 == 7'h00)
              d_alu = {2'b00, f3};
            else if (f7 == 7'h20)
              d_alu = {2'b01, f3};
            else
              d_ill = 1'b1;
          end else begin
            d_alu = {2'b00, f3};
          end
        end
        OPC_LUI: begin
          d_a  = 2'd2;
          d_b  = 3'd2;
          d_we = 1'b1;
        end
        OPC_AUIPC: begin
          d_a  = 2'd1;
          d_b  = 3'd2;
          d_we = 1'b1;
        end
        OPC_LOAD: begin
          d_b    = 3'd1;
          d_we   = 1'b1;
          d_wb   = 1'b1;
          d_mreq = 1'b1;
          d_size = f3;
          d_ld   = 1'b1;
          d_ill  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
        OPC_STORE: begin
          d_b    = 3'd3;
          d_mreq = 1'b1;
          d_mwe  = 1'b1;
          d_size = f3;
          d_st   = 1'b1;
          d_ill  = (f3 > 3'b010);
        end
        OPC_BRANCH: begin
          d_br  = 1'b1;
          d_alu = {2'b11, f3};
          d_ill = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_JAL: begin
          d_a   = 2'd1;
          d_b   = 3'd4;
          d_we  = 1'b1;
          d_jal = 1'b1;
        end
        OPC_JALR: begin
          d_a    = 2'd1;
          d_b    = 3'd4;
          d_we   = 1'b1;
          d_jalr = 2'b01;
          d_ill  = (f3 != 3'b000);
        end
        OPC_MISC: begin
          d_ill = (f3 != 3'b000);
        end
        OPC_SYSTEM: begin
          if (f3 == 3'b000) begin
            d_mret = 1'b1;
            d_jalr = 2'b10;
          end else if (f3[2] == 1'b0) begin
            d_csrop = {1'b0, f3[1:0]};
            d_csr   = 1'b1;
            d_we    = 1'b1;
          end else begin
            d_ill = 1'b1;
          end
        end
        default: d_ill = 1'b1;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Halfword needs bit0 clear, word needs both low bits clear.
  always_comb begin
    misal = 1'b0;
    if (d_ld || d_st) begin
      unique case (d_size[1:0])
        2'b01:   misal = mem_addr_lo[0];
        2'b10:   misal = (mem_addr_lo != 2'b00);
        default: misal = 1'b0;
      endcase
    end
  end
`else
  logic unused_lo;
  assign unused_lo = ^mem_addr_lo;
  assign misal     = 1'b0;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DECODE;
      wait_cnt <= '0;
      int_pend <= 1'b0;
      cause_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      int_pend <= pend_nxt;
      cause_q  <= cause_nxt;
    end
  end

  // Next-state and output logic; everything is forced low during reset.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = wait_cnt;
    pend_nxt      = int_pend;
    cause_nxt     = cause_q;
    src_A         = 2'd0;
    src_B         = 3'd0;
    ALUOp         = 5'd0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_size      = 3'd0;
    gpr_we_a      = 1'b0;
    wb_src_sel    = 1'b0;
    illegal_instr = 1'b0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 2'b00;
    CSROp         = 3'd0;
    csr           = 1'b0;
    enpc          = 1'b0;
    INT_RST       = 1'b0;
    trap_cause    = 32'd0;
    if (!rst) begin
      unique case (state)
        DECODE: begin
          if (int_req || int_pend) begin
            state_nxt = TRAP;
            cause_nxt = CAUSE_IRQ;
            pend_nxt  = 1'b0;
          end else if (d_ill) begin
            illegal_instr = 1'b1;
            state_nxt     = TRAP;
            cause_nxt     = CAUSE_ILL;
          end else if (misal) begin
            state_nxt = TRAP;
            cause_nxt = d_st ? CAUSE_SMIS : CAUSE_LMIS;
          end else begin
            src_A      = d_a;
            src_B      = d_b;
            ALUOp      = d_alu;
            mem_req    = d_mreq;
            mem_we     = d_mwe;
            mem_size   = d_size;
            wb_src_sel = d_wb;
            branch     = d_br;
            jal        = d_jal;
            jalr       = d_jalr;
            CSROp      = d_csrop;
            csr        = d_csr;
            if (d_ld || d_st) begin
              if (mem_ready) begin
                gpr_we_a = d_we;
                enpc     = 1'b1;
              end else begin
                state_nxt = MEM_WAIT;
                cnt_nxt   = CNT_W'(1);
              end
            end else begin
              gpr_we_a = d_we;
              enpc     = 1'b1;
              INT_RST  = d_mret;
            end
          end
        end
        MEM_WAIT: begin
          src_A      = d_a;
          src_B      = d_b;
          ALUOp      = d_alu;
          mem_we     = d_mwe;
          mem_size   = d_size;
          wb_src_sel = d_wb;
          // Request stays up through the last allowed cycle; a late
          // mem_ready there still completes the access.
          mem_req    = 1'b1;
          pend_nxt   = int_pend | int_req;
          if (mem_ready) begin
            gpr_we_a  = d_we;
            enpc      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DECODE;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            cnt_nxt   = '0;
            state_nxt = TRAP;
            cause_nxt = d_st ? CAUSE_SFLT : CAUSE_LFLT;
          end else begin
            cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
        TRAP: begin
          CSROp      = 3'b100;
          jalr       = 2'b11;
          enpc       = 1'b1;
          trap_cause = cause_q;
          state_nxt  = DECODE;
        end
        default: state_nxt = DECODE;
      endcase
    end
  end

endmodule
